// File: rtl/sram_pkg.sv
// Shared constants and FSM state type for the two-port SRAM bank.
package sram_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/sram_bank_2p_if.sv
// Request/response bundle for the two-port SRAM bank.
// Port A reads and writes, port B only reads.
interface sram_bank_2p_if import sram_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);

    logic [DEPTH-1:0] wordA;
    logic [DEPTH-1:0] wordB;
    logic             ReadEn;
    logic             WriteEn;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] outA;
    logic [WIDTH-1:0] outB;
    logic             validA;
    logic             validB;
    logic             busy;
    logic             onehot_err;

    modport master (
        output wordA, wordB, ReadEn, WriteEn, in,
        input  outA, outB, validA, validB, busy, onehot_err
    );

    modport slave (
        input  wordA, wordB, ReadEn, WriteEn, in,
        output outA, outB, validA, validB, busy, onehot_err
    );

endinterface

// File: rtl/sram_bank_2p_onehot_enc.sv
// One-hot row select to binary row index.
// legal is set only when exactly one select bit is high.
module onehot_enc #(
    parameter int DEPTH = 32
) (
    input  logic [DEPTH-1:0]         sel,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic                     legal
);

    localparam int AW = $clog2(DEPTH);

    // OR together the indices of all set bits; only meaningful when legal
    always_comb begin
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) idx = idx | AW'(i);
        end
    end

    // Non-zero and clearing the lowest set bit leaves nothing
    assign legal = (sel != '0) && ((sel & (sel - 1'b1)) == '0);

endmodule

// File: rtl/sram_bank_2p.sv
// Two-port SRAM bank: port A read/write, port B read-only, one-hot row
// selects, registered reads with one cycle latency, write-through on
// same-cycle read/write, and an optional zero-fill sweep after reset.
module sram_bank_2p import sram_pkg::*; #(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          srclkpos,
    input  logic          reset,
    sram_bank_2p_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    rowA;
    logic [AW-1:0]    rowB;
    logic             legalA;
    logic             legalB;
    state_t           state;
    logic [AW-1:0]    ptr;
    logic             clrPend;
    logic [WIDTH-1:0] mem [DEPTH];

    logic idle;
    logic rdA;
    logic wrA;
    logic rdB;
    logic errNow;

    onehot_enc #(.DEPTH(DEPTH)) encA (
        .sel   (bus.wordA),
        .idx   (rowA),
        .legal (legalA)
    );

    onehot_enc #(.DEPTH(DEPTH)) encB (
        .sel   (bus.wordB),
        .idx   (rowB),
        .legal (legalB)
    );

    // Requests are only honoured outside the clear sweep
    assign idle   = (state == IDLE);
    assign rdA    = bus.ReadEn  && idle && legalA;
    assign wrA    = bus.WriteEn && idle && legalA;
    assign rdB    = bus.ReadEn  && idle && legalB;
    assign errNow = idle && (((bus.ReadEn || bus.WriteEn) && !legalA) ||
                             (bus.ReadEn && !legalB));
    assign bus.busy = (state == CLEAR);

    // Sweep control: the sweep is armed by reset and starts on the first
    // cycle after release, so an aborted sweep always restarts at row 0
    always_ff @(posedge srclkpos) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            clrPend <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state)
                IDLE: begin
                    if (clrPend) begin
                        state   <= CLEAR;
                        ptr     <= '0;
                        clrPend <= 1'b0;
                    end
                end
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == AW'(DEPTH - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array write port: sweep zeroes take priority, no reset on the array
    always_ff @(posedge srclkpos) begin
        if (!reset) begin
            if (state == CLEAR) mem[ptr] <= '0;
            else if (wrA)       mem[rowA] <= bus.in;
        end
    end

    // Registered read data, valid pulses and sticky select error
    always_ff @(posedge srclkpos) begin
        if (reset) begin
            bus.outA       <= '0;
            bus.outB       <= '0;
            bus.validA     <= 1'b0;
            bus.validB     <= 1'b0;
            bus.onehot_err <= 1'b0;
        end else begin
            bus.validA <= rdA;
            bus.validB <= rdB;
            if (rdA) bus.outA <= wrA ? bus.in : mem[rowA];
            if (rdB) bus.outB <= (wrA && (rowB == rowA)) ? bus.in : mem[rowB];
            if (errNow) bus.onehot_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_bank_2p.sv
// Directed bench for sram_bank_2p: reset values, clear sweep, reads,
// write-through, select errors and sweep abort by reset.
module tb_sram_bank_2p;

    localparam int W = 16;
    localparam int D = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sram_bank_2p_if #(.WIDTH(W), .DEPTH(D)) bus ();

    sram_bank_2p #(.WIDTH(W), .DEPTH(D), .CLEAR_ON_RESET(1)) dut (
        .srclkpos (clk),
        .reset    (reset),
        .bus      (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleIn();
        bus.ReadEn  = 1'b0;
        bus.WriteEn = 1'b0;
        bus.wordA   = '0;
        bus.wordB   = '0;
        bus.in      = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [D-1:0] oh(input int r);
        logic [D-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    // Read every row on A and the mirrored row on B; all must be zero
    task automatic readAllZero(input string tag);
        for (int r = 0; r < D; r++) begin
            bus.ReadEn = 1'b1;
            bus.wordA  = oh(r);
            bus.wordB  = oh(D - 1 - r);
            tick();
            idleIn();
            check($sformatf("%s_A%0d", tag, r), 32'(bus.outA), 32'h0);
            check($sformatf("%s_B%0d", tag, D - 1 - r), 32'(bus.outB), 32'h0);
            check($sformatf("%s_vA%0d", tag, r), 32'(bus.validA), 32'h1);
            check($sformatf("%s_vB%0d", tag, r), 32'(bus.validB), 32'h1);
        end
    endtask

    initial begin
        int cnt;
        idleIn();

        // reset values
        reset = 1'b1;
        tick();
        tick();
        check("rst_outA",   32'(bus.outA),       32'h0);
        check("rst_outB",   32'(bus.outB),       32'h0);
        check("rst_validA", 32'(bus.validA),     32'h0);
        check("rst_validB", 32'(bus.validB),     32'h0);
        check("rst_err",    32'(bus.onehot_err), 32'h0);
        check("rst_busy",   32'(bus.busy),       32'h0);

        // first sweep: busy for exactly DEPTH cycles
        reset = 1'b0;
        tick();
        cnt = 0;
        while (bus.busy && cnt < 200) begin
            cnt++;
            tick();
        end
        check("sweep1_len", 32'(cnt), 32'd32);
        readAllZero("sweep1");

        // write row 7 then read it on both ports
        bus.WriteEn = 1'b1;
        bus.wordA   = oh(7);
        bus.in      = 16'hA5A5;
        tick();
        idleIn();
        check("wr7_noValid", 32'(bus.validA), 32'h0);
        bus.ReadEn = 1'b1;
        bus.wordA  = oh(7);
        bus.wordB  = oh(7);
        tick();
        idleIn();
        check("rd7_outA",   32'(bus.outA),   32'hA5A5);
        check("rd7_outB",   32'(bus.outB),   32'hA5A5);
        check("rd7_validA", 32'(bus.validA), 32'h1);
        check("rd7_validB", 32'(bus.validB), 32'h1);
        tick();
        check("hold_outA",   32'(bus.outA),   32'hA5A5);
        check("hold_validA", 32'(bus.validA), 32'h0);
        check("hold_validB", 32'(bus.validB), 32'h0);

        // same-cycle write+read, both ports on the written row
        bus.ReadEn  = 1'b1;
        bus.WriteEn = 1'b1;
        bus.wordA   = oh(3);
        bus.wordB   = oh(3);
        bus.in      = 16'h1234;
        tick();
        idleIn();
        check("wt3_outA", 32'(bus.outA), 32'h1234);
        check("wt3_outB", 32'(bus.outB), 32'h1234);
        bus.ReadEn = 1'b1;
        bus.wordA  = oh(3);
        bus.wordB  = oh(7);
        tick();
        idleIn();
        check("rd3_outA", 32'(bus.outA), 32'h1234);
        check("rd7b_outB", 32'(bus.outB), 32'hA5A5);

        // same-cycle write row 4, port B reads another row
        bus.ReadEn  = 1'b1;
        bus.WriteEn = 1'b1;
        bus.wordA   = oh(4);
        bus.wordB   = oh(3);
        bus.in      = 16'h5678;
        tick();
        idleIn();
        check("wt4_outA",   32'(bus.outA), 32'h5678);
        check("wt4_outB_3", 32'(bus.outB), 32'h1234);

        // multi-hot select on B: B suppressed, A normal, error sticky
        bus.ReadEn = 1'b1;
        bus.wordA  = oh(7);
        bus.wordB  = 32'h0000_0003;
        tick();
        idleIn();
        check("mh_validB", 32'(bus.validB),     32'h0);
        check("mh_outB",   32'(bus.outB),       32'h1234);
        check("mh_validA", 32'(bus.validA),     32'h1);
        check("mh_outA",   32'(bus.outA),       32'hA5A5);
        check("mh_err",    32'(bus.onehot_err), 32'h1);
        tick();
        check("mh_errSticky", 32'(bus.onehot_err), 32'h1);

        // fill every row with non-zero data, then leave data on the outputs
        for (int r = 0; r < D; r++) begin
            bus.WriteEn = 1'b1;
            bus.wordA   = oh(r);
            bus.in      = 16'hC000 | 16'(r);
            tick();
        end
        idleIn();
        bus.ReadEn = 1'b1;
        bus.wordA  = oh(5);
        bus.wordB  = oh(6);
        tick();
        idleIn();
        check("fill_outA", 32'(bus.outA), 32'hC005);
        check("fill_outB", 32'(bus.outB), 32'hC006);

        // reset clears outputs and error, then abort the sweep at cycle 10
        reset = 1'b1;
        tick();
        check("rst2_outA", 32'(bus.outA),       32'h0);
        check("rst2_outB", 32'(bus.outB),       32'h0);
        check("rst2_err",  32'(bus.onehot_err), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("abort_busyPre", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        tick();
        check("abort_busy", 32'(bus.busy), 32'h0);
        reset = 1'b0;

        // restarted sweep runs a full DEPTH cycles; a write mid-sweep is dropped
        tick();
        cnt = 0;
        while (bus.busy && cnt < 200) begin
            cnt++;
            if (cnt == 20) begin
                bus.ReadEn  = 1'b1;
                bus.WriteEn = 1'b1;
                bus.wordA   = oh(2);
                bus.wordB   = '0;
                bus.in      = 16'hBEEF;
            end
            tick();
            idleIn();
            if (cnt == 20) begin
                check("busy_validA", 32'(bus.validA),     32'h0);
                check("busy_validB", 32'(bus.validB),     32'h0);
                check("busy_err",    32'(bus.onehot_err), 32'h0);
            end
        end
        check("sweep2_len", 32'(cnt), 32'd32);
        readAllZero("sweep2");

        // illegal select with no request leaves the error clear
        bus.wordA = '0;
        bus.wordB = 32'h0000_0003;
        tick();
        idleIn();
        check("noreq_err", 32'(bus.onehot_err), 32'h0);

        // zero-hot write: nothing written, error set
        bus.WriteEn = 1'b1;
        bus.wordA   = '0;
        bus.in      = 16'hFFFF;
        tick();
        idleIn();
        check("zh_err",    32'(bus.onehot_err), 32'h1);
        check("zh_validA", 32'(bus.validA),     32'h0);
        bus.ReadEn = 1'b1;
        bus.wordA  = oh(0);
        bus.wordB  = oh(D - 1);
        tick();
        idleIn();
        check("zh_row0",  32'(bus.outA), 32'h0);
        check("zh_row31", 32'(bus.outB), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
